// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the in-order CPU pipeline.
//   - Default register-file geometry (data width, register count).
//   - sb_entry_t: one scoreboard stage, {valid, addr}.
//   - Opcode-class to operand-usage table. Decode uses it to drive the
//     register file's rs_used / rt_used qualifiers.
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int CPU_DATA_W   = 32;
  localparam int CPU_NUM_REGS = 16;

  // Scoreboard address field is sized for the largest supported register
  // file (256 entries). Smaller files zero-extend into it.
  localparam int SB_ADDR_W = 8;

  typedef struct packed {
    logic                 valid;
    logic [SB_ADDR_W-1:0] addr;
  } sb_entry_t;

  typedef enum logic [2:0] {
    OP_ALU_RR = 3'd0,
    OP_ALU_RI = 3'd1,
    OP_LOAD   = 3'd2,
    OP_STORE  = 3'd3,
    OP_BRANCH = 3'd4,
    OP_JUMP   = 3'd5,
    OP_LUI    = 3'd6,
    OP_NOP    = 3'd7
  } op_class_e;

  // Operand usage encoding: bit 1 = rs is read, bit 0 = rt is read.
  localparam logic [1:0] USE_NONE = 2'b00;
  localparam logic [1:0] USE_RT   = 2'b01;
  localparam logic [1:0] USE_RS   = 2'b10;
  localparam logic [1:0] USE_BOTH = 2'b11;

  function automatic logic [1:0] op_uses(input op_class_e op);
    logic [1:0] uses;
    case (op)
      OP_ALU_RR: uses = USE_BOTH;
      OP_ALU_RI: uses = USE_RS;
      OP_LOAD:   uses = USE_RS;
      OP_STORE:  uses = USE_BOTH;
      OP_BRANCH: uses = USE_BOTH;
      default:   uses = USE_NONE;
    endcase
    return uses;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_hazard_pipe.sv
// ---------------------------------------------------------------------------
// hazard_pipe
// HAZ_DEPTH-stage shift register of in-flight destination registers.
// Stage 0 is the youngest entry; the last stage falls off every clock.
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset, clears every stage
//   flush_i      synchronous squash: all stages invalid after the edge
//   load_i       an instruction with a destination issues this cycle
//   load_addr_i  its destination register
//   stage_o      per-stage {valid, addr}, stage 0 first
//   pending_o    bit i set when register i sits in any valid stage
// ---------------------------------------------------------------------------
module hazard_pipe
  import cpu_pkg::*;
#(
  parameter int HAZ_DEPTH = 3,
  parameter int NUM_REGS  = CPU_NUM_REGS,
  parameter int ADDR_W    = $clog2(NUM_REGS)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            flush_i,
  input  logic                            load_i,
  input  logic [ADDR_W-1:0]               load_addr_i,
  output sb_entry_t [HAZ_DEPTH-1:0]       stage_o,
  output logic [NUM_REGS-1:0]             pending_o
);

  sb_entry_t [HAZ_DEPTH-1:0] stage_q;
  sb_entry_t [HAZ_DEPTH-1:0] stage_d;

  // Shift everything one stage older. Flush wins over the load so a squashed
  // cycle cannot leave a fresh entry behind.
  always_comb begin
    stage_d = stage_q;
    if (flush_i) begin
      stage_d = '0;
    end else begin
      for (int k = HAZ_DEPTH - 1; k > 0; k--) begin
        stage_d[k] = stage_q[k-1];
      end
      stage_d[0].valid = load_i;
      stage_d[0].addr  = load_i ? SB_ADDR_W'(load_addr_i) : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  // Pending mask is decoded from the registered stages only, so it has no
  // combinational path back to the issue inputs.
  always_comb begin
    pending_o = '0;
    for (int k = 0; k < HAZ_DEPTH; k++) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (stage_q[k].valid && (stage_q[k].addr == SB_ADDR_W'(i))) begin
          pending_o[i] = 1'b1;
        end
      end
    end
  end

  assign stage_o = stage_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
// Register file with RAW-hazard scoreboard, between decode and write-back.
// Ports:
//   clk, rst              clock (rising edge) and async active-low reset
//   wr_en/wr_addr/wr_data write-back port
//   iss_valid             decode presents an instruction
//   iss_rd_en, iss_rd     it writes register iss_rd (also the rd_data address)
//   rs_addr/rs_used       source operand s and its "read by opcode" qualifier
//   rt_addr/rt_used       source operand t and its qualifier
//   flush                 squash every in-flight destination
//   rd_data/rs_data/rt_data  combinational reads
//   stall                 presented instruction must wait
//   pending               bit i = register i is an in-flight destination
// ---------------------------------------------------------------------------
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int DATA_W    = CPU_DATA_W,
  parameter int NUM_REGS  = CPU_NUM_REGS,
  parameter int HAZ_DEPTH = 3,
  parameter bit ZERO_REG  = 1'b1,
  parameter bit BYPASS    = 1'b1,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                iss_valid,
  input  logic                iss_rd_en,
  input  logic [ADDR_W-1:0]   iss_rd,
  input  logic [ADDR_W-1:0]   rs_addr,
  input  logic                rs_used,
  input  logic [ADDR_W-1:0]   rt_addr,
  input  logic                rt_used,
  input  logic                flush,
  output logic [DATA_W-1:0]   rd_data,
  output logic [DATA_W-1:0]   rs_data,
  output logic [DATA_W-1:0]   rt_data,
  output logic                stall,
  output logic [NUM_REGS-1:0] pending
);

  // With bypass the oldest stage is writing back this very cycle and its
  // value is forwarded, so it no longer needs to hold the consumer.
  localparam int WIN_LEN = BYPASS ? HAZ_DEPTH - 1 : HAZ_DEPTH;

  logic [DATA_W-1:0]         regs_q [NUM_REGS];
  sb_entry_t [HAZ_DEPTH-1:0] stage;
  logic                      wr_live;
  logic                      rs_hit;
  logic                      rt_hit;
  logic                      rs_haz;
  logic                      rt_haz;
  logic                      load;

  assign wr_live = wr_en && !(ZERO_REG && (wr_addr == '0));

  // Register array; writes to the hardwired zero register are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_live) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              live,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata
  );
    if (ZERO_REG && (addr == '0)) begin
      return '0;
    end
    if (BYPASS && live && (addr == waddr)) begin
      return wdata;
    end
    return stored;
  endfunction

  assign rd_data = read_port(iss_rd,  regs_q[iss_rd],  wr_live, wr_addr, wr_data);
  assign rs_data = read_port(rs_addr, regs_q[rs_addr], wr_live, wr_addr, wr_data);
  assign rt_data = read_port(rt_addr, regs_q[rt_addr], wr_live, wr_addr, wr_data);

  // Match each operand against the stages still inside the hazard window.
  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    for (int k = 0; k < WIN_LEN; k++) begin
      if (stage[k].valid && (stage[k].addr == SB_ADDR_W'(rs_addr))) begin
        rs_hit = 1'b1;
      end
      if (stage[k].valid && (stage[k].addr == SB_ADDR_W'(rt_addr))) begin
        rt_hit = 1'b1;
      end
    end
  end

  assign rs_haz = iss_valid && rs_used && !(ZERO_REG && (rs_addr == '0)) && rs_hit;
  assign rt_haz = iss_valid && rt_used && !(ZERO_REG && (rt_addr == '0)) && rt_hit;
  assign stall  = rs_haz || rt_haz;

  // A stalled instruction does not enter the pipe, leaving a bubble.
  assign load = iss_valid && iss_rd_en && !stall && !(ZERO_REG && (iss_rd == '0));

  hazard_pipe #(
    .HAZ_DEPTH (HAZ_DEPTH),
    .NUM_REGS  (NUM_REGS),
    .ADDR_W    (ADDR_W)
  ) u_hazard_pipe (
    .clk_i       (clk),
    .rst_ni      (rst),
    .flush_i     (flush),
    .load_i      (load),
    .load_addr_i (iss_rd),
    .stage_o     (stage),
    .pending_o   (pending)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_regfile_scoreboard
// Drives one stimulus stream into two register files: instance B with
// write-back bypass and instance N without. Both use 16x32, HAZ_DEPTH=3,
// ZERO_REG=1. A timestamp model (which cycle each destination issued, and
// the last flush/reset cycle) predicts every output each cycle; directed
// checks pin the model with hand-computed values.
// ---------------------------------------------------------------------------
module tb_regfile_scoreboard;
  import cpu_pkg::*;

  localparam int DW    = 32;
  localparam int NR    = 16;
  localparam int DEPTH = 3;
  localparam int MAXC  = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [3:0]    wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          iss_valid = 1'b0;
  logic          iss_rd_en = 1'b0;
  logic [3:0]    iss_rd = '0;
  logic [3:0]    rs_addr = '0;
  logic          rs_used = 1'b0;
  logic [3:0]    rt_addr = '0;
  logic          rt_used = 1'b0;
  logic          flush = 1'b0;

  logic [DW-1:0] rdB, rsB, rtB, rdN, rsN, rtN;
  logic          stallB, stallN;
  logic [NR-1:0] pendB, pendN;

  always #5 clk = ~clk;

  regfile_scoreboard #(.HAZ_DEPTH(DEPTH), .ZERO_REG(1'b1), .BYPASS(1'b1)) dutB (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_valid(iss_valid), .iss_rd_en(iss_rd_en), .iss_rd(iss_rd),
    .rs_addr(rs_addr), .rs_used(rs_used), .rt_addr(rt_addr), .rt_used(rt_used),
    .flush(flush), .rd_data(rdB), .rs_data(rsB), .rt_data(rtB),
    .stall(stallB), .pending(pendB)
  );

  regfile_scoreboard #(.HAZ_DEPTH(DEPTH), .ZERO_REG(1'b1), .BYPASS(1'b0)) dutN (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_valid(iss_valid), .iss_rd_en(iss_rd_en), .iss_rd(iss_rd),
    .rs_addr(rs_addr), .rs_used(rs_used), .rt_addr(rt_addr), .rt_used(rt_used),
    .flush(flush), .rd_data(rdN), .rs_data(rsN), .rt_data(rtN),
    .stall(stallN), .pending(pendN)
  );

  int checks = 0;
  int passes = 0;

  // Model state: index 0 = bypass instance, 1 = no-bypass instance.
  int            cyc = 0;
  int            issued [2][MAXC];
  int            lastFlush [2];
  logic [DW-1:0] mem [NR];
  bit            modelOn = 1'b0;

  task automatic checkVal(input string name, input string inst,
                          input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s inst=%s got=%h expected=%h at %0t", name, inst, got, exp, $time);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] gotB, input logic [31:0] gotN,
                             input logic [31:0] expB, input logic [31:0] expN);
    checkVal(name, "B", gotB, expB);
    checkVal(name, "N", gotN, expN);
  endtask

  // A destination issued j cycles ago is still in flight for j=1..DEPTH,
  // unless a flush or reset happened at or after its issue cycle.
  function automatic bit inFlight(int inst, int j, output int addr);
    int idx;
    idx  = cyc - j;
    addr = -1;
    if (idx < 0 || idx <= lastFlush[inst]) return 1'b0;
    addr = issued[inst][idx];
    return addr >= 0;
  endfunction

  function automatic bit modelHaz(int inst, logic [3:0] a, logic used);
    int win;
    int ad;
    win = (inst == 0) ? DEPTH - 1 : DEPTH;
    if (!iss_valid || !used || a == 4'd0) return 1'b0;
    for (int j = 1; j <= win; j++) begin
      if (inFlight(inst, j, ad) && ad == int'(a)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [NR-1:0] modelPend(int inst);
    logic [NR-1:0] p;
    int ad;
    p = '0;
    for (int j = 1; j <= DEPTH; j++) begin
      if (inFlight(inst, j, ad)) p[ad] = 1'b1;
    end
    return p;
  endfunction

  function automatic logic [DW-1:0] modelRead(int inst, logic [3:0] a);
    if (a == 4'd0) return '0;
    if (inst == 0 && wr_en && wr_addr == a) return wr_data;
    return mem[a];
  endfunction

  // Model update at each rising edge, using the inputs of the ending cycle.
  always @(posedge clk) begin
    bit st [2];
    for (int m = 0; m < 2; m++) begin
      st[m] = modelHaz(m, rs_addr, rs_used) | modelHaz(m, rt_addr, rt_used);
    end
    if (!rst) begin
      for (int r = 0; r < NR; r++) mem[r] = '0;
      lastFlush[0] = cyc;
      lastFlush[1] = cyc;
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (flush) lastFlush[m] = cyc;
        else if (iss_valid && iss_rd_en && !st[m] && iss_rd != 4'd0) issued[m][cyc] = int'(iss_rd);
      end
      if (wr_en && wr_addr != 4'd0) mem[wr_addr] = wr_data;
    end
    if (cyc < MAXC - 1) cyc++;
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (rst && modelOn) begin
      checkOutput("m_rd",    rdB, rdN, modelRead(0, iss_rd),  modelRead(1, iss_rd));
      checkOutput("m_rs",    rsB, rsN, modelRead(0, rs_addr), modelRead(1, rs_addr));
      checkOutput("m_rt",    rtB, rtN, modelRead(0, rt_addr), modelRead(1, rt_addr));
      checkOutput("m_stall", 32'(stallB), 32'(stallN),
                  32'(modelHaz(0, rs_addr, rs_used) | modelHaz(0, rt_addr, rt_used)),
                  32'(modelHaz(1, rs_addr, rs_used) | modelHaz(1, rt_addr, rt_used)));
      checkOutput("m_pend",  32'(pendB), 32'(pendN), 32'(modelPend(0)), 32'(modelPend(1)));
    end
  end

  task automatic applyStimulus(input logic iv, input logic rde, input logic [3:0] rd,
                               input logic [3:0] rs, input logic rsu,
                               input logic [3:0] rt, input logic rtu,
                               input logic we, input logic [3:0] wa, input logic [31:0] wd,
                               input logic fl);
    @(posedge clk);
    #1;
    iss_valid = iv;  iss_rd_en = rde; iss_rd = rd;
    rs_addr   = rs;  rs_used   = rsu;
    rt_addr   = rt;  rt_used   = rtu;
    wr_en     = we;  wr_addr   = wa;  wr_data = wd;
    flush     = fl;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [1:0] u;
    for (int m = 0; m < 2; m++) begin
      lastFlush[m] = -1;
      for (int c = 0; c < MAXC; c++) issued[m][c] = -1;
    end
    for (int r = 0; r < NR; r++) mem[r] = '0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    modelOn = 1'b1;

    // Put some state in, then reset mid-run.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 4'd5, 32'h55, 0);
    applyStimulus(1, 1, 4'd2, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 4'd5, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("pend_pre_rst", 32'(pendB), 32'(pendN), 32'h4, 32'h4);
    checkOutput("r5_pre_rst", rsB, rsN, 32'h55, 32'h55);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("pend_in_rst", 32'(pendB), 32'(pendN), 32'h0, 32'h0);
    checkOutput("r5_in_rst", rsB, rsN, 32'h0, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < NR; i++) begin
      applyStimulus(0, 0, 4'(i), 4'(i), 0, 4'(i), 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("rst_rd", rdB, rdN, 32'h0, 32'h0);
      checkOutput("rst_rs", rsB, rsN, 32'h0, 32'h0);
      checkOutput("rst_rt", rtB, rtN, 32'h0, 32'h0);
      checkOutput("rst_stall", 32'(stallB), 32'(stallN), 32'h0, 32'h0);
      checkOutput("rst_pend", 32'(pendB), 32'(pendN), 32'h0, 32'h0);
    end

    // Zero register ignores writes and never forwards.
    applyStimulus(0, 0, 0, 0, 1, 0, 1, 1, 4'd0, 32'hDEADBEEF, 0);
    @(negedge clk);
    checkOutput("r0_wrcyc", rsB, rsN, 32'h0, 32'h0);
    applyStimulus(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("r0_after", rtB, rtN, 32'h0, 32'h0);

    // Basic write/read, plus same-cycle forwarding only on B.
    applyStimulus(0, 0, 0, 4'd5, 1, 4'd5, 1, 1, 4'd5, 32'h12345678, 0);
    @(negedge clk);
    checkOutput("r5_wrcyc", rsB, rsN, 32'h12345678, 32'h0);
    applyStimulus(0, 0, 0, 4'd5, 1, 4'd5, 1, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("r5_rs", rsB, rsN, 32'h12345678, 32'h12345678);
    checkOutput("r5_rt", rtB, rtN, 32'h12345678, 32'h12345678);

    // RAW hazard on r3: B stalls 2 cycles, N stalls 3.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 4'd3, 32'h11, 0);
    idle();
    applyStimulus(1, 1, 4'd3, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("raw_c0_stall", 32'(stallB), 32'(stallN), 32'h0, 32'h0);
    applyStimulus(1, 0, 0, 4'd3, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("raw_c1_stall", 32'(stallB), 32'(stallN), 32'h1, 32'h1);
    checkOutput("raw_c1_pend", 32'(pendB), 32'(pendN), 32'h8, 32'h8);
    applyStimulus(1, 0, 0, 4'd3, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("raw_c2_stall", 32'(stallB), 32'(stallN), 32'h1, 32'h1);
    applyStimulus(1, 0, 0, 4'd3, 1, 0, 0, 1, 4'd3, 32'hA5, 0);
    @(negedge clk);
    checkOutput("raw_c3_stall", 32'(stallB), 32'(stallN), 32'h0, 32'h1);
    checkOutput("raw_c3_rs", rsB, rsN, 32'hA5, 32'h11);
    checkOutput("raw_c3_pend", 32'(pendB), 32'(pendN), 32'h8, 32'h8);
    applyStimulus(1, 0, 0, 4'd3, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("raw_c4_stall", 32'(stallB), 32'(stallN), 32'h0, 32'h0);
    checkOutput("raw_c4_rs", rsB, rsN, 32'hA5, 32'hA5);
    checkOutput("raw_c4_pend", 32'(pendB), 32'(pendN), 32'h0, 32'h0);

    // Operand qualifiers and zero-register destination.
    repeat (3) idle();
    applyStimulus(1, 1, 4'd3, 0, 0, 0, 0, 0, 0, 0, 0);
    u = op_uses(OP_ALU_RI);
    applyStimulus(1, 1, 4'd0, 4'd4, u[1], 4'd3, u[0], 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("qual_rt_unused", 32'(stallB), 32'(stallN), 32'h0, 32'h0);
    applyStimulus(1, 0, 0, 4'd0, 1, 4'd0, 1, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("qual_r0_stall", 32'(stallB), 32'(stallN), 32'h0, 32'h0);
    checkOutput("qual_r0_pend", 32'(pendB), 32'(pendN), 32'h8, 32'h8);

    // Flush squashes r7 and blocks the same-cycle issue of r8; write commits.
    repeat (3) idle();
    applyStimulus(1, 1, 4'd7, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("fl_c0_pend", 32'(pendB), 32'(pendN), 32'h0, 32'h0);
    applyStimulus(1, 1, 4'd8, 0, 0, 0, 0, 1, 4'd9, 32'h99, 1);
    @(negedge clk);
    checkOutput("fl_c1_pend", 32'(pendB), 32'(pendN), 32'h80, 32'h80);
    applyStimulus(1, 0, 0, 4'd7, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("fl_c2_stall", 32'(stallB), 32'(stallN), 32'h0, 32'h0);
    checkOutput("fl_c2_pend", 32'(pendB), 32'(pendN), 32'h0, 32'h0);
    applyStimulus(0, 0, 0, 4'd9, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("fl_wr_commit", rsB, rsN, 32'h99, 32'h99);

    // Write-after-write does not stall; pending accumulates.
    applyStimulus(1, 1, 4'd6, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 4'd6, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("waw_stall", 32'(stallB), 32'(stallN), 32'h0, 32'h0);
    checkOutput("waw_pend", 32'(pendB), 32'(pendN), 32'h40, 32'h40);
    applyStimulus(1, 1, 4'd2, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("waw_pend2", 32'(pendB), 32'(pendN), 32'h40, 32'h40);
    idle();
    @(negedge clk);
    checkOutput("waw_pend3", 32'(pendB), 32'(pendN), 32'h44, 32'h44);

    repeat (4) idle();
    @(negedge clk);
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
